paddle_pot_sequencer: RTL and testbench
=======================================

Name: paddle_pot_sequencer

Overview:
Emulates the two paddle potentiometer/RC-timing inputs of the ay38500NTSC chip (pinLPin, pinRPin). It takes digital up/down buttons and analog joystick axes, arbitrates between them per player, and holds a 9-bit position per paddle. Once per field it converts each position into a scanline countdown, so each pot pin goes high a position-dependent number of lines after VSYNC. It sits between hps_io/keyboard decoding and the chip, clocked on the chip clock.

Parameters:
POS_INIT, 128, position loaded at reset and on recentre
POS_MAX, 255, upper saturation limit of position
STEP_SLOW, 5, digital step per field when speed_fast=0
STEP_FAST, 8, digital step per field when speed_fast=1
DEADZONE, 8, analog magnitude at or below which stick is treated as idle

Ports:
clk  in  1  chip clock (7.159 MHz)
reset  in  1  synchronous, active-low reset
hs  in  1  horizontal sync, active-high pulse
vs  in  1  vertical sync, active-high pulse
speed_fast  in  1  selects STEP_FAST
recentre  in  1  level; both positions return to POS_INIT at next field
p1_up, p1_down, p2_up, p2_down  in  1 each  digital buttons
p1_axis, p2_axis  in  8 each  signed analog Y axis (-128..127, negative = up)
lp_in  out  1  left pot pin, high when left countdown is zero
rp_in  out  1  right pot pin, high when right countdown is zero
p1_pos, p2_pos  out  9 each  current paddle positions (debug/OSD)
p1_src, p2_src  out  1 each  active source, 0 = digital, 1 = analog

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset.
- On reset: positions = POS_INIT, countdowns = 0, so lp_in = rp_in = 1. src = 0 and edge registers = 0.
- Edge detection: hs and vs are registered each cycle. A field event is vs=1 with vs_q=0; a line event is hs=1 with hs_q=0.
- If a field event and a line event occur in the same cycle, the field event wins and the line event is dropped.
- Field event, per channel, all in that single cycle:
  - The countdown is loaded from the current (pre-update) position.
  - The position then updates by source, described below.
- Line event: each non-zero countdown decrements by 1. A zero countdown stays at 0.
- lp_in/rp_in are combinational (countdown == 0) off registered countdowns. They therefore change the cycle after the edge.
- Source arbitration: a per-channel 2-state FSM, DIGITAL and ANALOG, evaluated on field events only.
  - DIGITAL -> ANALOG when |axis| > DEADZONE.
  - ANALOG -> DIGITAL when up or down is asserted.
  - If both conditions hold together, DIGITAL wins.
- Digital update, with step = speed_fast ? STEP_FAST : STEP_SLOW:
  - up=1: pos = max(pos - step, 0), saturating with no wrap.
  - else down=1: pos = min(pos + step, POS_MAX).
  - up and down together: up wins.
  - Neither: hold.
- Analog update: pos = axis + 128 (unsigned 0..255). This is absolute, not incremental. An idle stick within DEADZONE still maps directly.
- recentre=1 at a field event overrides both sources: pos = POS_INIT. The FSM state is unchanged.
- Arithmetic is done 10-bit signed internally so the subtraction saturates correctly.
- No vs for a long time: countdowns reach 0 and the pins stay high. Positions hold.
- reset deasserted mid-field: the countdown stays 0 until the next field event.

Decomposition:
- Package paddle_pkg holds:
  - typedef pos_t (logic [8:0]);
  - enum src_e {SRC_DIGITAL, SRC_ANALOG};
  - the default step and deadzone constants.
- One sub-module, paddle_channel. It contains the FSM, position and countdown for one paddle, with inputs field_evt, line_evt, up, down, axis, speed_fast and recentre.
- The top instantiates two channels and a shared edge detector.

Test Plan:
1. Reset, then 3 fields with no input -> p1_pos = p2_pos = 128. After each vs rise, lp_in goes low and returns high on the 128th hs rise.
2. Hold p1_up with speed_fast=0 for 30 fields -> pos goes 128, 123, ... 3, then 0 and stays 0 with no wrap. Then hold p1_down with speed_fast=1 for 40 fields -> saturates at 255.
3. p2_axis = -128 at a field -> p2_src = 1 and p2_pos = 0. On the next field, rp_in is already high the cycle after the vs edge. p2_axis = +127 -> p2_pos = 255.
4. p2_axis = +100 together with p2_down at one field -> src stays DIGITAL and pos = 128 + 5.
5. vs and hs rise in the same cycle with countdown = 10 -> countdown reloads to pos. No decrement occurs on that cycle.
6. recentre=1 while in ANALOG with axis = -50 -> pos = 128 and src stays 1. Assert reset mid-countdown (countdown = 60) -> next cycle lp_in = 1 and pos = 128.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared types and default constants for the paddle pot sequencer.
package paddle_pkg;

  typedef logic [8:0] pos_t;

  typedef enum logic {
    SRC_DIGITAL = 1'b0,
    SRC_ANALOG  = 1'b1
  } src_e;

  localparam int unsigned POS_INIT_DEF  = 128;
  localparam int unsigned POS_MAX_DEF   = 255;
  localparam int unsigned STEP_SLOW_DEF = 5;
  localparam int unsigned STEP_FAST_DEF = 8;
  localparam int unsigned DEADZONE_DEF  = 8;

  // Magnitude of a signed 8-bit stick axis; -128 maps to 128, so 9 bits are needed.
  function automatic logic [8:0] axis_mag(input logic [7:0] axis);
    logic [8:0] ext;
    ext = {axis[7], axis};
    axis_mag = ext[8] ? (~ext + 9'd1) : ext;
  endfunction

endpackage

// File: rtl/paddle_pot_sequencer_channel.sv
// One paddle: source arbitration FSM, 9-bit position and scanline countdown.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int unsigned POS_INIT  = POS_INIT_DEF,
  parameter int unsigned POS_MAX   = POS_MAX_DEF,
  parameter int unsigned STEP_SLOW = STEP_SLOW_DEF,
  parameter int unsigned STEP_FAST = STEP_FAST_DEF,
  parameter int unsigned DEADZONE  = DEADZONE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       field_evt,
  input  logic       line_evt,
  input  logic       up,
  input  logic       down,
  input  logic [7:0] axis,
  input  logic       speed_fast,
  input  logic       recentre,
  output pos_t       pos,
  output logic       src,
  output logic       pin
);

  localparam logic signed [9:0] STEP_SLOW_S = 10'(STEP_SLOW);
  localparam logic signed [9:0] STEP_FAST_S = 10'(STEP_FAST);
  localparam logic signed [9:0] POS_MAX_S   = 10'(POS_MAX);

  src_e src_q, src_d;
  pos_t pos_q, pos_d;
  pos_t count_q, count_d;

  logic              digital_req;
  logic              analog_req;
  logic signed [9:0] step_s;
  logic signed [9:0] pos_ext;
  logic signed [9:0] dec_s;
  logic signed [9:0] inc_s;
  pos_t              analog_pos;
  pos_t              digital_pos;

  // Per-field arithmetic: 10-bit signed so the subtraction can go below zero before clamping.
  always_comb begin
    digital_req = up | down;
    analog_req  = axis_mag(axis) > 9'(DEADZONE);
    step_s      = speed_fast ? STEP_FAST_S : STEP_SLOW_S;
    pos_ext     = $signed({1'b0, pos_q});
    dec_s       = pos_ext - step_s;
    inc_s       = pos_ext + step_s;
    analog_pos  = {1'b0, ~axis[7], axis[6:0]};
    digital_pos = pos_q;
    if (up) begin
      digital_pos = (dec_s < 10'sd0) ? '0 : dec_s[8:0];
    end else if (down) begin
      digital_pos = (inc_s > POS_MAX_S) ? POS_MAX_S[8:0] : inc_s[8:0];
    end
  end

  // Next-state: field events reload the countdown and update position; line events count down.
  always_comb begin
    src_d   = src_q;
    pos_d   = pos_q;
    count_d = count_q;
    if (field_evt) begin
      count_d = pos_q;
      case (src_q)
        SRC_DIGITAL: if (analog_req && !digital_req) src_d = SRC_ANALOG;
        SRC_ANALOG:  if (digital_req) src_d = SRC_DIGITAL;
        default:     src_d = SRC_DIGITAL;
      endcase
      if (recentre) begin
        pos_d = pos_t'(POS_INIT);
      end else if (src_d == SRC_ANALOG) begin
        pos_d = analog_pos;
      end else begin
        pos_d = digital_pos;
      end
    end else if (line_evt && (count_q != '0)) begin
      count_d = count_q - 9'd1;
    end
  end

  // Arbitration FSM plus position and countdown registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q   <= SRC_DIGITAL;
      pos_q   <= pos_t'(POS_INIT);
      count_q <= '0;
    end else begin
      src_q   <= src_d;
      pos_q   <= pos_d;
      count_q <= count_d;
    end
  end

  assign pos = pos_q;
  assign src = src_q;
  assign pin = (count_q == '0);

endmodule

// File: rtl/paddle_pot_sequencer.sv
// Two paddle channels sharing one hs/vs edge detector; drives the chip's pot pins.
module paddle_pot_sequencer
  import paddle_pkg::*;
#(
  parameter int unsigned POS_INIT  = POS_INIT_DEF,
  parameter int unsigned POS_MAX   = POS_MAX_DEF,
  parameter int unsigned STEP_SLOW = STEP_SLOW_DEF,
  parameter int unsigned STEP_FAST = STEP_FAST_DEF,
  parameter int unsigned DEADZONE  = DEADZONE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hs,
  input  logic       vs,
  input  logic       speed_fast,
  input  logic       recentre,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic [7:0] p1_axis,
  input  logic [7:0] p2_axis,
  output logic       lp_in,
  output logic       rp_in,
  output logic [8:0] p1_pos,
  output logic [8:0] p2_pos,
  output logic       p1_src,
  output logic       p2_src
);

  logic vs_q, vs_d;
  logic hs_q, hs_d;
  logic field_evt;
  logic line_evt;

  // Rising-edge detect; a field event swallows a line event landing in the same cycle.
  always_comb begin
    vs_d      = vs;
    hs_d      = hs;
    field_evt = vs & ~vs_q;
    line_evt  = hs & ~hs_q & ~field_evt;
  end

  // Sync edge registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vs_q <= 1'b0;
      hs_q <= 1'b0;
    end else begin
      vs_q <= vs_d;
      hs_q <= hs_d;
    end
  end

  paddle_channel #(
    .POS_INIT (POS_INIT),
    .POS_MAX  (POS_MAX),
    .STEP_SLOW(STEP_SLOW),
    .STEP_FAST(STEP_FAST),
    .DEADZONE (DEADZONE)
  ) u_left (
    .clk       (clk),
    .reset     (reset),
    .field_evt (field_evt),
    .line_evt  (line_evt),
    .up        (p1_up),
    .down      (p1_down),
    .axis      (p1_axis),
    .speed_fast(speed_fast),
    .recentre  (recentre),
    .pos       (p1_pos),
    .src       (p1_src),
    .pin       (lp_in)
  );

  paddle_channel #(
    .POS_INIT (POS_INIT),
    .POS_MAX  (POS_MAX),
    .STEP_SLOW(STEP_SLOW),
    .STEP_FAST(STEP_FAST),
    .DEADZONE (DEADZONE)
  ) u_right (
    .clk       (clk),
    .reset     (reset),
    .field_evt (field_evt),
    .line_evt  (line_evt),
    .up        (p2_up),
    .down      (p2_down),
    .axis      (p2_axis),
    .speed_fast(speed_fast),
    .recentre  (recentre),
    .pos       (p2_pos),
    .src       (p2_src),
    .pin       (rp_in)
  );

endmodule

// File: tb/tb_paddle_pot_sequencer.sv
// Scoreboard bench for paddle_pot_sequencer: driver queues expected outputs, monitor checks them.
module tb_paddle_pot_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hs = 1'b0, vs = 1'b0;
  logic       speed_fast = 1'b0, recentre = 1'b0;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [7:0] p1_axis = 8'd0, p2_axis = 8'd0;
  logic       lp_in, rp_in;
  logic [8:0] p1_pos, p2_pos;
  logic       p1_src, p2_src;

  paddle_pot_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .hs        (hs),
    .vs        (vs),
    .speed_fast(speed_fast),
    .recentre  (recentre),
    .p1_up     (p1_up),
    .p1_down   (p1_down),
    .p2_up     (p2_up),
    .p2_down   (p2_down),
    .p1_axis   (p1_axis),
    .p2_axis   (p2_axis),
    .lp_in     (lp_in),
    .rp_in     (rp_in),
    .p1_pos    (p1_pos),
    .p2_pos    (p2_pos),
    .p1_src    (p1_src),
    .p2_src    (p2_src)
  );

  // Free-running chip clock.
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [21:0] exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_item;
  int   checks = 0;
  int   failures = 0;

  logic [8:0] e_p1 = 9'd128, e_p2 = 9'd128;
  logic       e_s1 = 1'b0, e_s2 = 1'b0, e_lp = 1'b1, e_rp = 1'b1;

  task automatic pushExpected(input string name);
    exp_t t;
    t.name = name;
    t.exp  = {e_p1, e_p2, e_s1, e_s2, e_lp, e_rp};
    sb_q.push_back(t);
  endtask

  task automatic checkOutput(input string name, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got p1=%0d p2=%0d src=%b%b lp=%b rp=%b, expected p1=%0d p2=%0d src=%b%b lp=%b rp=%b",
               name, act[21:13], act[12:4], act[3], act[2], act[1], act[0],
               exp[21:13], exp[12:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One vs and/or hs pulse; the expected post-event outputs go into the scoreboard.
  task automatic applyStimulus(input bit do_vs, input bit do_hs, input string name);
    @(negedge clk);
    vs = do_vs;
    hs = do_hs;
    pushExpected(name);
    @(negedge clk);
    vs = 1'b0;
    hs = 1'b0;
  endtask

  task automatic applyReset(input string name);
    @(negedge clk);
    reset = 1'b0;
    e_p1 = 9'd128; e_p2 = 9'd128;
    e_s1 = 1'b0;   e_s2 = 1'b0;
    e_lp = 1'b1;   e_rp = 1'b1;
    pushExpected(name);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: each reset entry or sync rising edge makes the DUT present new outputs.
  initial begin
    logic vs_p, hs_p, rst_p, trig;
    vs_p = 1'b0; hs_p = 1'b0; rst_p = 1'b1;
    forever begin
      @(posedge clk);
      trig  = (!reset && rst_p) || (reset && ((vs && !vs_p) || (hs && !hs_p)));
      vs_p  = reset ? vs : 1'b0;
      hs_p  = reset ? hs : 1'b0;
      rst_p = reset;
      if (trig) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event: got output event, expected none queued");
        end else begin
          mon_item = sb_q.pop_front();
          checkOutput(mon_item.name, {p1_pos, p2_pos, p1_src, p2_src, lp_in, rp_in}, mon_item.exp);
        end
      end
    end
  end

  initial begin
    applyReset("reset_state");

    // Idle fields: pins drop after vs and rise on the 128th hs.
    for (int f = 0; f < 3; f++) begin
      e_lp = 1'b0; e_rp = 1'b0;
      applyStimulus(1'b1, 1'b0, "idle_field");
      for (int i = 0; i < 128; i++) begin
        if (i == 127) begin e_lp = 1'b1; e_rp = 1'b1; end
        applyStimulus(1'b0, 1'b1, "idle_line");
      end
    end

    // Slow up-steps saturate at 0.
    p1_up = 1'b1; speed_fast = 1'b0;
    for (int f = 0; f < 30; f++) begin
      e_lp = (e_p1 == 9'd0);
      e_rp = 1'b0;
      e_p1 = (e_p1 >= 9'd5) ? e_p1 - 9'd5 : 9'd0;
      applyStimulus(1'b1, 1'b0, "p1_up_slow");
    end
    // Fast down-steps saturate at 255.
    p1_up = 1'b0; p1_down = 1'b1; speed_fast = 1'b1;
    for (int f = 0; f < 40; f++) begin
      e_lp = (e_p1 == 9'd0);
      e_p1 = (e_p1 >= 9'd247) ? 9'd255 : e_p1 + 9'd8;
      applyStimulus(1'b1, 1'b0, "p1_down_fast");
    end
    p1_down = 1'b0; speed_fast = 1'b0;

    // Analog extremes on p2.
    p2_axis = 8'h80;
    e_lp = 1'b0; e_rp = 1'b0; e_s2 = 1'b1; e_p2 = 9'd0;
    applyStimulus(1'b1, 1'b0, "p2_axis_min");
    e_rp = 1'b1;
    applyStimulus(1'b1, 1'b0, "p2_pin_high_at_zero");
    p2_axis = 8'd127;
    e_rp = 1'b1; e_p2 = 9'd255;
    applyStimulus(1'b1, 1'b0, "p2_axis_max");
    p2_up = 1'b1;
    e_rp = 1'b0; e_s2 = 1'b0; e_p2 = 9'd250;
    applyStimulus(1'b1, 1'b0, "p2_button_leaves_analog");
    p2_up = 1'b0; p2_axis = 8'd0;

    // Digital wins when stick and button both request at one field.
    applyReset("reset_again");
    p2_axis = 8'd100; p2_down = 1'b1;
    e_lp = 1'b0; e_rp = 1'b0; e_p2 = 9'd133; e_s2 = 1'b0;
    applyStimulus(1'b1, 1'b0, "p2_digital_wins");
    p2_down = 1'b0; p2_axis = 8'd0;

    // Same-cycle vs+hs: countdown reloads to 10 with no decrement.
    p1_axis = 8'd138;
    e_lp = 1'b0; e_p1 = 9'd10; e_s1 = 1'b1; e_rp = 1'b0;
    applyStimulus(1'b1, 1'b0, "p1_analog_10");
    applyStimulus(1'b1, 1'b0, "p1_load_10");
    applyStimulus(1'b1, 1'b1, "vs_hs_same_cycle");
    for (int i = 0; i < 10; i++) begin
      if (i == 9) e_lp = 1'b1;
      applyStimulus(1'b0, 1'b1, "line_after_combined");
    end

    // Recentre in analog mode, then reset mid-countdown.
    p1_axis = 8'd206; recentre = 1'b1;
    e_p1 = 9'd128; e_s1 = 1'b1; e_lp = 1'b0; e_p2 = 9'd128; e_rp = 1'b0;
    applyStimulus(1'b1, 1'b0, "recentre_in_analog");
    recentre = 1'b0;
    e_p1 = 9'd78;
    applyStimulus(1'b1, 1'b0, "p1_analog_78");
    applyStimulus(1'b1, 1'b0, "p1_load_78");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, 1'b1, "line_to_60");
    end
    applyReset("reset_mid_countdown");

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
